// File: rtl/att_softmax.sv
// att_softmax: streaming softmax over one attention row.
// Scores are captured into a row buffer while tracking the running max, converted in place
// to power-of-two exponentials (32768 >> (max - s)), summed, then each element is normalised
// by a bit-serial restoring divider and emitted in input order.
module att_softmax #(
    parameter int unsigned ROW_LEN = 16,
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  i_score,
    input  logic             i_valid,
    output logic             busy,
    output logic [OUT_W-1:0] o_prob,
    output logic             o_valid,
    output logic             row_done
);

    localparam int unsigned IW = $clog2(ROW_LEN);
    // Exponentials are at most 32768, so the row sum needs log2(ROW_LEN) extra bits.
    localparam int unsigned SW = 16 + IW;
    localparam int unsigned CW = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {LOAD, EXP, DIV, OUT} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic signed [IN_W-1:0] max;
    logic [SW-1:0]          sum;
    logic [SW-1:0]          rem;
    logic [OUT_W:0]         q;
    logic [CW-1:0]          cnt;

    // Holds raw scores during LOAD, then exponentials (unsigned, low 16 bits) after EXP.
    logic [IN_W-1:0]        mem [ROW_LEN];

    logic [IN_W-1:0]        mem_rd;
    logic [IN_W:0]          d;
    logic [15:0]            e_val;
    logic [SW:0]            div_r;
    logic                   div_ge;
    logic [SW-1:0]          rem_next;
    logic [OUT_W:0]         q_next;
    logic                   last_elem;

    // Exponential approximation and one restoring-division step for the current element.
    always_comb begin
        mem_rd    = mem[idx];
        d         = {max[IN_W-1], max} - {mem_rd[IN_W-1], mem_rd};
        e_val     = (d < (IN_W + 1)'(16)) ? (16'h8000 >> d[3:0]) : 16'h0000;
        // Step 0 tests e against sum directly (quotient may reach 2^OUT_W); later steps shift.
        div_r     = (cnt == '0) ? (SW + 1)'(mem_rd[15:0]) : {rem, 1'b0};
        div_ge    = div_r >= {1'b0, sum};
        rem_next  = SW'(div_ge ? (div_r - {1'b0, sum}) : div_r);
        q_next    = {q[OUT_W-1:0], div_ge};
        last_elem = idx == IW'(ROW_LEN - 1);
    end

    // Row buffer: capture scores in LOAD, overwrite with exponentials in EXP.
    always_ff @(posedge clk) begin
        if (en) begin
            if (state == LOAD && i_valid) begin
                mem[idx] <= i_score;
            end else if (state == EXP) begin
                mem[idx] <= IN_W'(e_val);
            end
        end
    end

    // Main sequencer: LOAD -> EXP -> (DIV x (OUT_W+1) -> OUT) per element -> LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            idx    <= '0;
            max    <= '0;
            sum    <= '0;
            rem    <= '0;
            q      <= '0;
            cnt    <= '0;
            o_prob <= '0;
        end else if (en) begin
            unique case (state)
                LOAD: begin
                    if (i_valid) begin
                        if (idx == '0 || $signed(i_score) > max) begin
                            max <= i_score;
                        end
                        if (last_elem) begin
                            idx   <= '0;
                            sum   <= '0;
                            state <= EXP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                EXP: begin
                    sum <= sum + SW'(e_val);
                    if (last_elem) begin
                        idx   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    q   <= q_next;
                    if (cnt == CW'(OUT_W)) begin
                        // Quotient 2^OUT_W only occurs for a lone dominant element; clamp it.
                        o_prob <= q_next[OUT_W] ? {OUT_W{1'b1}} : q_next[OUT_W-1:0];
                        state  <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    cnt <= '0;
                    if (last_elem) begin
                        idx   <= '0;
                        state <= LOAD;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= DIV;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Strobes are gated by en so a stalled OUT cycle is reported only once it completes.
    always_comb begin
        busy     = state != LOAD;
        o_valid  = (state == OUT) && en;
        row_done = o_valid && last_elem;
    end

endmodule

// File: tb/tb_att_softmax.sv
// Self-checking bench for att_softmax: a reference model pushes expected probabilities into a
// scoreboard; an independent monitor pops and compares on every o_valid.
module tb_att_softmax;

    localparam int RL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] i_score = '0;
    logic        i_valid = 1'b0;
    logic        busy;
    logic [7:0]  o_prob;
    logic        o_valid;
    logic        row_done;

    att_softmax #(
        .ROW_LEN(RL),
        .IN_W(16),
        .OUT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .i_score(i_score),
        .i_valid(i_valid),
        .busy(busy),
        .o_prob(o_prob),
        .o_valid(o_valid),
        .row_done(row_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int prob;
        bit last;
        int gap;  // required cycles since previous o_valid, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_t = 0;
    bit   finish_req = 0;
    bit   timeout_flag = 0;
    bit   rand_en = 0;
    int   stall_left = 0;
    logic signed [15:0] row_s[RL];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: softmax with base-2 exponent, e = 32768 / 2^(max - s), floor(e * 256 / sum).
    task automatic push_row(input int stall_at, input int stall_len);
        int mx, sum, e[RL];
        exp_t x;
        mx = int'(row_s[0]);
        for (int i = 1; i < RL; i++) if (int'(row_s[i]) > mx) mx = int'(row_s[i]);
        sum = 0;
        for (int i = 0; i < RL; i++) begin
            e[i] = (mx - int'(row_s[i]) < 16) ? (32768 / (1 << (mx - int'(row_s[i])))) : 0;
            sum += e[i];
        end
        for (int i = 0; i < RL; i++) begin
            x.prob = int'((longint'(e[i]) * 256) / sum);
            if (x.prob > 255) x.prob = 255;
            x.last = (i == RL - 1);
            if (i == 0 || rand_en) x.gap = 0;
            else x.gap = (i == stall_at) ? 10 + stall_len : 10;
            exp_q.push_back(x);
        end
    endtask

    // One clock: inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (stall_left > 0) begin
            en = 1'b0;
            stall_left--;
        end else begin
            en = rand_en ? ($urandom_range(0, 4) != 0) : 1'b1;
        end
    endtask

    // Busy rows get random junk on i_valid/i_score; it must be ignored.
    task automatic junk();
        i_valid = busy ? 1'($urandom) : 1'b0;
        i_score = 16'($urandom);
    endtask

    task automatic send_row(input bit gaps);
        int k = 0;
        while (k < RL) begin
            tick();
            i_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_score = row_s[k];
            if (en && i_valid) k++;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 4000; c++) begin
            tick();
            junk();
            if (exp_q.size() == 0) return;
        end
        timeout_flag = 1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            n_tests++;
            if (busy !== 1'b0 || o_valid !== 1'b0 || row_done !== 1'b0 || o_prob !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: busy=%0b o_valid=%0b row_done=%0b o_prob=%0d, need 0",
                         busy, o_valid, row_done, o_prob);
            end
        end else if (o_valid === 1'b1) begin
            n_tests++;
            if (en !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_while_stalled: en=%0b o_valid=1, need o_valid=0", en);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: o_prob=%0d with empty scoreboard", o_prob);
            end else begin
                x = exp_q.pop_front();
                if (int'(o_prob) != x.prob || row_done !== x.last) begin
                    n_fail++;
                    $display("FAIL prob: got o_prob=%0d row_done=%0b, need %0d/%0b",
                             o_prob, row_done, x.prob, x.last);
                end
                if (x.gap != 0) begin
                    n_tests++;
                    if (cyc - last_t != x.gap) begin
                        n_fail++;
                        $display("FAIL spacing: got %0d cycles, need %0d", cyc - last_t, x.gap);
                    end
                end
            end
            last_t = cyc;
        end else if (row_done !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL row_done_alone: row_done=%0b without o_valid, need 0", row_done);
        end
        if (finish_req) begin
            n_tests++;
            if (timeout_flag || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: timeout=%0b pending=%0d, need 0/0",
                         timeout_flag, exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        int mode;
        repeat (3) tick();
        rst = 1'b0;

        // Uniform row: every probability 16, 10 cycles apart.
        for (int i = 0; i < RL; i++) row_s[i] = 16'sd5;
        push_row(-1, 0);
        send_row(1'b0);
        drain();

        // Dominant score saturates, the rest underflow to 0.
        for (int i = 0; i < RL; i++) row_s[i] = (i == 3) ? 16'sd100 : 16'sd0;
        push_row(-1, 0);
        send_row(1'b0);
        drain();

        // Two-level row with a 5-cycle stall during element 7's division.
        for (int i = 0; i < RL; i++) row_s[i] = (i % 2 == 0) ? 16'sd1 : 16'sd0;
        push_row(7, 5);
        send_row(1'b0);
        while (exp_q.size() > 9) begin
            tick();
            junk();
        end
        tick();
        junk();
        tick();
        junk();
        stall_left = 5;
        drain();

        // Reset during EXP discards the row; a clean uniform row follows.
        for (int i = 0; i < RL; i++) row_s[i] = -16'sd7;
        send_row(1'b0);
        repeat (3) begin
            tick();
            junk();
        end
        rst = 1'b1;
        i_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < RL; i++) row_s[i] = 16'sd5;
        push_row(-1, 0);
        send_row(1'b0);
        drain();

        // Randomised rows, some with random en stalls and input gaps.
        for (int r = 0; r < 30; r++) begin
            mode = $urandom_range(0, 2);
            for (int i = 0; i < RL; i++) begin
                if (mode == 0) row_s[i] = 16'($signed($urandom_range(0, 40)) - 20);
                else if (mode == 1) row_s[i] = 16'($urandom);
                else row_s[i] = (i == 0) ? 16'($urandom) : row_s[0];
            end
            rand_en = (r % 3 == 1);
            push_row(-1, 0);
            send_row(r % 2 == 1);
            drain();
            rand_en = 0;
        end

        finish_req = 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1, "watchdog");
    end

endmodule
